// File: rtl/instr_mem_boot_fetch_if.sv
// rtl/instr_mem_boot_fetch_if.sv - fetch, runtime-write and status signals of the boot-loaded instruction memory
interface instr_mem_boot_fetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic [DATA_W-1:0] Q;
    logic              q_valid;
    logic              Wren;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] Din;
    logic              boot_done;
    logic              parity_err;

    modport master (
        output fetch_req, fetch_addr, Wren, wr_addr, Din,
        input  fetch_ready, Q, q_valid, boot_done, parity_err
    );

    modport slave (
        input  fetch_req, fetch_addr, Wren, wr_addr, Din,
        output fetch_ready, Q, q_valid, boot_done, parity_err
    );
endinterface

// File: rtl/instr_mem_boot_fetch.sv
// rtl/instr_mem_boot_fetch.sv - instruction memory loaded by a boot FSM, 1-cycle req/valid fetch port
// Optional stored even parity per word is enabled by defining INSTR_MEM_PARITY_EN.
module instr_mem_boot_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    instr_mem_boot_fetch_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    if (DATA_W < 16) begin : g_bad_data_w
        $error("instr_mem_boot_fetch: DATA_W must be >= 16");
    end
    if (ADDR_W < 3) begin : g_bad_addr_w
        $error("instr_mem_boot_fetch: DEPTH must be >= 8");
    end

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              boot_we;
    logic              boot_last;
    logic [DATA_W-1:0] boot_data;
    logic              run;
    logic              fetch_go, wr_go, fwd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q_r;
    logic              q_valid_r;
    logic              boot_done_r;

    function automatic logic [15:0] boot16(input logic [ADDR_W-1:0] a);
        case (int'(a))
            0:       return 16'h40A0;
            1:       return 16'h6000;
            2:       return 16'h8081;
            3:       return 16'h60A2;
            4:       return 16'hA081;
            5, 6:    return 16'h40A0;
            default: return 16'h0000;
        endcase
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        boot_we    = 1'b0;
        boot_last  = (cnt == {ADDR_W{1'b1}});
        boot_data  = DATA_W'(boot16(cnt));
        case (state)
            INIT: begin
                boot_we  = 1'b1;
                cnt_next = cnt + ADDR_W'(1);
                if (boot_last) state_next = RUN;
            end
            RUN: ;
            default: state_next = INIT;
        endcase
    end

    // Fetch and runtime writes only exist in RUN; INIT owns the write port.
    assign run      = (state == RUN);
    assign fetch_go = run & bus.fetch_req;
    assign wr_go    = run & bus.Wren;
    assign fwd      = fetch_go & wr_go & (bus.wr_addr == bus.fetch_addr);
    assign mem_we   = boot_we | wr_go;
    assign mem_wa   = boot_we ? cnt : bus.wr_addr;
    assign mem_wd   = boot_we ? boot_data : bus.Din;

    always_ff @(posedge Clock) begin
        if (!Reset && mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_r         <= '0;
            q_valid_r   <= 1'b0;
            boot_done_r <= 1'b0;
        end else begin
            q_valid_r <= fetch_go;
            if (fetch_go) q_r <= fwd ? bus.Din : mem[bus.fetch_addr];
            if (boot_we && boot_last) boot_done_r <= 1'b1;
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic par [DEPTH];
    logic perr_r;

    always_ff @(posedge Clock) begin
        if (!Reset && mem_we) par[mem_wa] <= ^mem_wd;
    end

    // Forwarded data never went through storage, so it is never checked.
    always_ff @(posedge Clock) begin
        if (Reset) perr_r <= 1'b0;
        else       perr_r <= fetch_go & ~fwd & ((^mem[bus.fetch_addr]) ^ par[bus.fetch_addr]);
    end

    assign bus.parity_err = perr_r;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.fetch_ready = run;
    assign bus.Q           = q_r;
    assign bus.q_valid     = q_valid_r;
    assign bus.boot_done   = boot_done_r;
endmodule
